// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read/2-write register file with an issue scoreboard and registered busy count.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read bypass (port B over A).
module reg_file_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic [ADDR_W-1:0] Read_reg1,
   input  logic [ADDR_W-1:0] Read_reg2,
   output logic [DATA_W-1:0] Read_data1,
   output logic [DATA_W-1:0] Read_data2,
   output logic              Read_busy1,
   output logic              Read_busy2,
   input  logic              Write_en_a,
   input  logic              Write_en_b,
   input  logic [ADDR_W-1:0] Write_reg_a,
   input  logic [ADDR_W-1:0] Write_reg_b,
   input  logic [DATA_W-1:0] Write_data_a,
   input  logic [DATA_W-1:0] Write_data_b,
   input  logic              Issue_en,
   input  logic [ADDR_W-1:0] Issue_reg,
   output logic [ADDR_W:0]   Busy_count
);
   localparam int NREG = 2 ** ADDR_W;
   logic [DATA_W-1:0] r_regs [NREG];
   logic [NREG-1:0]   r_busy;
   logic [ADDR_W:0]   r_cnt;
   logic [NREG-1:0]   w_busy_nxt;
   logic [ADDR_W:0]   w_pop;
   logic              w_wa;
   logic              w_wb;
   logic              w_iss;
   logic [ADDR_W-1:0] w_ra [2];
   logic [DATA_W-1:0] w_rd [2];
   logic              w_rb [2];
   // register 0 is hardwired: writes and issues to it are dropped here
   assign w_wa  = Write_en_a && (Write_reg_a != '0);
   assign w_wb  = Write_en_b && (Write_reg_b != '0);
   assign w_iss = Issue_en && (Issue_reg != '0);
   // next busy vector: writes clear, issue applied last so it wins on the same register
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wa) w_busy_nxt[Write_reg_a] = 1'b0;
      if (w_wb) w_busy_nxt[Write_reg_b] = 1'b0;
      if (w_iss) w_busy_nxt[Issue_reg] = 1'b1;
   end
   // population count of the current busy vector, captured into r_cnt at the next edge
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < NREG; i++) w_pop = w_pop + (ADDR_W+1)'(r_busy[i]);
   end
   // storage, scoreboard and count; port B is assigned after A so it wins a collision
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
         r_busy <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_wa) r_regs[Write_reg_a] <= Write_data_a;
         if (w_wb) r_regs[Write_reg_b] <= Write_data_b;
         r_busy <= w_busy_nxt;
         r_cnt  <= w_pop;
      end
   end
   assign w_ra[0]    = Read_reg1;
   assign w_ra[1]    = Read_reg2;
   assign Read_data1 = w_rd[0];
   assign Read_data2 = w_rd[1];
   assign Read_busy1 = w_rb[0];
   assign Read_busy2 = w_rb[1];
   assign Busy_count = r_cnt;
   // combinational read ports; r_regs[0] and r_busy[0] are never written so index 0 reads 0
   for (genvar p = 0; p < 2; p++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
      logic w_hb;
      logic w_ha;
      assign w_hb    = w_wb && (Write_reg_b == w_ra[p]);
      assign w_ha    = w_wa && (Write_reg_a == w_ra[p]);
      assign w_rd[p] = w_hb ? Write_data_b : w_ha ? Write_data_a : r_regs[w_ra[p]];
      assign w_rb[p] = (w_hb || w_ha) ? (w_iss && (Issue_reg == w_ra[p])) : r_busy[w_ra[p]];
`else
      assign w_rd[p] = r_regs[w_ra[p]];
      assign w_rb[p] = r_busy[w_ra[p]];
`endif
   end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb; honours REGFILE_BYPASS_EN when defined.
module tb_reg_file_sb;
   localparam int DW = 32;
   localparam int AW = 5;
   logic          Clk = 1'b0;
   logic          Rst_n;
   logic [AW-1:0] Read_reg1, Read_reg2;
   logic [DW-1:0] Read_data1, Read_data2;
   logic          Read_busy1, Read_busy2;
   logic          Write_en_a, Write_en_b;
   logic [AW-1:0] Write_reg_a, Write_reg_b;
   logic [DW-1:0] Write_data_a, Write_data_b;
   logic          Issue_en;
   logic [AW-1:0] Issue_reg;
   logic [AW:0]   Busy_count;

   typedef struct {
      string       n;
      logic [31:0] v;
   } exp_t;
   exp_t        q[$];
   exp_t        e;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_regs [32];
   logic [31:0] m_busy;
   logic [5:0]  m_cnt;

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .Read_reg1(Read_reg1), .Read_reg2(Read_reg2),
      .Read_data1(Read_data1), .Read_data2(Read_data2),
      .Read_busy1(Read_busy1), .Read_busy2(Read_busy2),
      .Write_en_a(Write_en_a), .Write_en_b(Write_en_b),
      .Write_reg_a(Write_reg_a), .Write_reg_b(Write_reg_b),
      .Write_data_a(Write_data_a), .Write_data_b(Write_data_b),
      .Issue_en(Issue_en), .Issue_reg(Issue_reg),
      .Busy_count(Busy_count)
   );

   always #5 Clk = ~Clk;

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy = '0;
      m_cnt  = '0;
   endtask

   task automatic idle();
      Write_en_a = 0; Write_en_b = 0; Issue_en = 0;
   endtask

   // one rising edge; reference model follows the inputs presented at that edge
   task automatic tick();
      @(posedge Clk);
      if (Rst_n) begin
         m_cnt = 6'($countones(m_busy));
         if (Write_en_a && Write_reg_a != 0) begin m_regs[Write_reg_a] = Write_data_a; m_busy[Write_reg_a] = 1'b0; end
         if (Write_en_b && Write_reg_b != 0) begin m_regs[Write_reg_b] = Write_data_b; m_busy[Write_reg_b] = 1'b0; end
         if (Issue_en && Issue_reg != 0) m_busy[Issue_reg] = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      Rst_n = 0; idle();
      Read_reg1 = 5; Read_reg2 = 0;
      Write_reg_a = 0; Write_reg_b = 0; Issue_reg = 0;
      Write_data_a = 0; Write_data_b = 0;
      model_clear();
      repeat (2) tick();
      q.push_back('{"rst_data1", 32'h0});
      q.push_back('{"rst_busy1", 32'h0});
      q.push_back('{"rst_count", 32'h0});
      e = q.pop_front(); checks++; if (Read_data1 !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_data1, e.v); end
      e = q.pop_front(); checks++; if (Read_busy1 !== e.v[0]) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_busy1, e.v[0]); end
      e = q.pop_front(); checks++; if (Busy_count !== e.v[5:0]) begin errors++; $display("FAIL %s got %h exp %h", e.n, Busy_count, e.v[5:0]); end
      Rst_n = 1;
      tick();
   endtask

   task automatic test_write();
      Write_en_a = 1; Write_reg_a = 5; Write_data_a = 32'h1234_5678;
      tick(); idle();
      q.push_back('{"r5_data", 32'h1234_5678});
      Read_reg1 = 5; #1;
      e = q.pop_front(); checks++; if (Read_data1 !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_data1, e.v); end
      Write_en_a = 1; Write_reg_a = 0; Write_data_a = 32'hFFFF_FFFF;
      tick(); idle();
      q.push_back('{"r0_data", 32'h0});
      q.push_back('{"r0_busy", 32'h0});
      Read_reg1 = 0; #1;
      e = q.pop_front(); checks++; if (Read_data1 !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_data1, e.v); end
      e = q.pop_front(); checks++; if (Read_busy1 !== e.v[0]) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_busy1, e.v[0]); end
   endtask

   task automatic test_same_index();
      Write_en_a = 1; Write_reg_a = 7; Write_data_a = 32'h11;
      Write_en_b = 1; Write_reg_b = 7; Write_data_b = 32'h22;
      tick(); idle();
      q.push_back('{"r7_b_wins", 32'h22});
      Read_reg2 = 7; #1;
      e = q.pop_front(); checks++; if (Read_data2 !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_data2, e.v); end
   endtask

   task automatic test_busy();
      Issue_en = 1; Issue_reg = 3; tick();
      Issue_reg = 4; tick(); idle();
      q.push_back('{"cnt_lag", 32'd1});
      #1;
      e = q.pop_front(); checks++; if (Busy_count !== e.v[5:0]) begin errors++; $display("FAIL %s got %0d exp %0d", e.n, Busy_count, e.v[5:0]); end
      tick();
      q.push_back('{"busy_r3", 32'h1});
      q.push_back('{"busy_r4", 32'h1});
      q.push_back('{"cnt_2", 32'd2});
      Read_reg1 = 3; Read_reg2 = 4; #1;
      e = q.pop_front(); checks++; if (Read_busy1 !== e.v[0]) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_busy1, e.v[0]); end
      e = q.pop_front(); checks++; if (Read_busy2 !== e.v[0]) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_busy2, e.v[0]); end
      e = q.pop_front(); checks++; if (Busy_count !== e.v[5:0]) begin errors++; $display("FAIL %s got %0d exp %0d", e.n, Busy_count, e.v[5:0]); end
      Write_en_a = 1; Write_reg_a = 3; Write_data_a = 32'h3333;
      tick(); idle();
      q.push_back('{"busy_r3_clr", 32'h0});
      q.push_back('{"cnt_still_2", 32'd2});
      #1;
      e = q.pop_front(); checks++; if (Read_busy1 !== e.v[0]) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_busy1, e.v[0]); end
      e = q.pop_front(); checks++; if (Busy_count !== e.v[5:0]) begin errors++; $display("FAIL %s got %0d exp %0d", e.n, Busy_count, e.v[5:0]); end
      tick();
      q.push_back('{"cnt_1", 32'd1});
      e = q.pop_front(); checks++; if (Busy_count !== e.v[5:0]) begin errors++; $display("FAIL %s got %0d exp %0d", e.n, Busy_count, e.v[5:0]); end
   endtask

   task automatic test_issue_write();
      Issue_en = 1; Issue_reg = 9;
      Write_en_a = 1; Write_reg_a = 9; Write_data_a = 32'hAB;
      tick(); idle();
      q.push_back('{"r9_data", 32'hAB});
      q.push_back('{"r9_busy", 32'h1});
      Read_reg1 = 9; #1;
      e = q.pop_front(); checks++; if (Read_data1 !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_data1, e.v); end
      e = q.pop_front(); checks++; if (Read_busy1 !== e.v[0]) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_busy1, e.v[0]); end
      Issue_en = 1; Issue_reg = 4;
      tick(); idle(); tick();
      q.push_back('{"reissue_cnt", 32'd2});
      q.push_back('{"reissue_busy", 32'h1});
      Read_reg2 = 4; #1;
      e = q.pop_front(); checks++; if (Busy_count !== e.v[5:0]) begin errors++; $display("FAIL %s got %0d exp %0d", e.n, Busy_count, e.v[5:0]); end
      e = q.pop_front(); checks++; if (Read_busy2 !== e.v[0]) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_busy2, e.v[0]); end
   endtask

   task automatic test_dual_clear();
      Write_en_a = 1; Write_reg_a = 4; Write_data_a = 32'h44;
      Write_en_b = 1; Write_reg_b = 9; Write_data_b = 32'h99;
      Issue_en = 1; Issue_reg = 10;
      tick(); idle();
      q.push_back('{"dual_busy_r4", 32'h0});
      q.push_back('{"dual_busy_r9", 32'h0});
      Read_reg1 = 4; Read_reg2 = 9; #1;
      e = q.pop_front(); checks++; if (Read_busy1 !== e.v[0]) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_busy1, e.v[0]); end
      e = q.pop_front(); checks++; if (Read_busy2 !== e.v[0]) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_busy2, e.v[0]); end
      tick();
      q.push_back('{"dual_busy_r10", 32'h1});
      q.push_back('{"dual_cnt", 32'd1});
      Read_reg1 = 10; #1;
      e = q.pop_front(); checks++; if (Read_busy1 !== e.v[0]) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_busy1, e.v[0]); end
      e = q.pop_front(); checks++; if (Busy_count !== e.v[5:0]) begin errors++; $display("FAIL %s got %0d exp %0d", e.n, Busy_count, e.v[5:0]); end
   endtask

   task automatic test_bypass();
      Write_en_a = 1; Write_reg_a = 6; Write_data_a = 32'h33;
      tick(); idle();
      Read_reg1 = 6; Read_reg2 = 6;
      Write_en_a = 1; Write_reg_a = 6; Write_data_a = 32'h55;
`ifdef REGFILE_BYPASS_EN
      q.push_back('{"byp_a", 32'h55});
`else
      q.push_back('{"byp_a", 32'h33});
`endif
      #2;
      e = q.pop_front(); checks++; if (Read_data1 !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_data1, e.v); end
      Write_en_b = 1; Write_reg_b = 6; Write_data_b = 32'h66;
      Issue_en = 1; Issue_reg = 6;
`ifdef REGFILE_BYPASS_EN
      q.push_back('{"byp_b", 32'h66});
      q.push_back('{"byp_busy", 32'h1});
`else
      q.push_back('{"byp_b", 32'h33});
      q.push_back('{"byp_busy", 32'h0});
`endif
      #1;
      e = q.pop_front(); checks++; if (Read_data2 !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_data2, e.v); end
      e = q.pop_front(); checks++; if (Read_busy2 !== e.v[0]) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_busy2, e.v[0]); end
      tick(); idle();
      q.push_back('{"r6_stored", 32'h66});
      #1;
      e = q.pop_front(); checks++; if (Read_data1 !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_data1, e.v); end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 150; c++) begin
         Write_en_a = 1'($urandom_range(0, 1)); Write_reg_a = 5'($urandom_range(0, 7)); Write_data_a = $urandom;
         Write_en_b = 1'($urandom_range(0, 1)); Write_reg_b = 5'($urandom_range(0, 7)); Write_data_b = $urandom;
         Issue_en   = 1'($urandom_range(0, 1)); Issue_reg   = 5'($urandom_range(0, 7));
         tick(); idle();
         Read_reg1 = 5'($urandom_range(0, 7));
         Read_reg2 = 5'($urandom_range(0, 7));
         q.push_back('{"rnd_data1", m_regs[Read_reg1]});
         q.push_back('{"rnd_busy2", {31'h0, m_busy[Read_reg2]}});
         q.push_back('{"rnd_count", {26'h0, m_cnt}});
         #1;
         e = q.pop_front(); checks++; if (Read_data1 !== e.v) begin errors++; $display("FAIL %s cyc %0d got %h exp %h", e.n, c, Read_data1, e.v); end
         e = q.pop_front(); checks++; if (Read_busy2 !== e.v[0]) begin errors++; $display("FAIL %s cyc %0d got %h exp %h", e.n, c, Read_busy2, e.v[0]); end
         e = q.pop_front(); checks++; if (Busy_count !== e.v[5:0]) begin errors++; $display("FAIL %s cyc %0d got %0d exp %0d", e.n, c, Busy_count, e.v[5:0]); end
      end
   endtask

   task automatic test_async_reset();
      for (int r = 1; r <= 4; r++) begin
         Write_en_a = 1; Write_reg_a = 5'(r); Write_data_a = 32'hA0 + r;
         Issue_en = 1; Issue_reg = 5'(r);
         tick();
      end
      idle(); tick();
      @(negedge Clk); #2;
      Rst_n = 0; model_clear();
      #1;
      for (int r = 1; r <= 4; r++) begin
         Read_reg1 = 5'(r); Read_reg2 = 5'(r);
         q.push_back('{"arst_data", 32'h0});
         q.push_back('{"arst_busy", 32'h0});
         #1;
         e = q.pop_front(); checks++; if (Read_data1 !== e.v) begin errors++; $display("FAIL %s r%0d got %h exp %h", e.n, r, Read_data1, e.v); end
         e = q.pop_front(); checks++; if (Read_busy2 !== e.v[0]) begin errors++; $display("FAIL %s r%0d got %h exp %h", e.n, r, Read_busy2, e.v[0]); end
      end
      q.push_back('{"arst_count", 32'h0});
      e = q.pop_front(); checks++; if (Busy_count !== e.v[5:0]) begin errors++; $display("FAIL %s got %0d exp %0d", e.n, Busy_count, e.v[5:0]); end
      Write_en_a = 1; Write_reg_a = 2; Write_data_a = 32'hDEAD;
      Issue_en = 1; Issue_reg = 2;
      tick();
      idle();
      Rst_n = 1;
      Read_reg1 = 2;
      q.push_back('{"rst_discard_data", 32'h0});
      q.push_back('{"rst_discard_busy", 32'h0});
      #1;
      e = q.pop_front(); checks++; if (Read_data1 !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_data1, e.v); end
      e = q.pop_front(); checks++; if (Read_busy1 !== e.v[0]) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_busy1, e.v[0]); end
      Write_en_b = 1; Write_reg_b = 2; Write_data_b = 32'hBEEF;
      tick(); idle();
      q.push_back('{"post_rst_write", 32'hBEEF});
      #1;
      e = q.pop_front(); checks++; if (Read_data1 !== e.v) begin errors++; $display("FAIL %s got %h exp %h", e.n, Read_data1, e.v); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_same_index();
      test_busy();
      test_issue_write();
      test_dual_clear();
      test_bypass();
      test_back_to_back();
      test_async_reset();
      if (q.size() != 0) begin
         checks++; errors++;
         $display("FAIL queue_drain left %0d exp 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, register data width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 5, register index width; register count NREG = 2**ADDR_W.
REQ-003 Port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port Rst_n  input  1  asynchronous, active-low reset.
REQ-005 Ports Read_reg1, Read_reg2  input  ADDR_W  read port 1/2 register index.
REQ-006 Ports Read_data1, Read_data2  output  DATA_W  read port 1/2 data.
REQ-007 Ports Read_busy1, Read_busy2  output  1  scoreboard busy bit of the indexed register.
REQ-008 Ports Write_en_a, Write_en_b  input  1  write port A/B enable.
REQ-009 Ports Write_reg_a, Write_reg_b  input  ADDR_W  write port A/B register index.
REQ-010 Ports Write_data_a, Write_data_b  input  DATA_W  write port A/B data.
REQ-011 Port Issue_en  input  1  mark a destination register pending.
REQ-012 Port Issue_reg  input  ADDR_W  destination register index being issued.
REQ-013 Port Busy_count  output  ADDR_W+1  registered count of busy registers.

Function
REQ-014 Reads SHALL be combinational; register 0 SHALL always read 0 with busy 0.
REQ-015 An enabled write to a nonzero index SHALL update that register at the next rising edge; writes to index 0 SHALL be ignored.
REQ-016 When both write ports target the same nonzero index in one cycle, port B data SHALL be stored.
REQ-017 Issue_en with nonzero Issue_reg SHALL set that register's busy bit at the next edge; issue to index 0 SHALL be ignored.
REQ-018 An enabled write on either port SHALL clear the target register's busy bit at the next edge.
REQ-019 Issue and write to the same register in one cycle: busy SHALL end set (issue wins); data SHALL still be written.
REQ-020 Issue to an already-busy register SHALL leave it busy (no count change).
REQ-021 Busy_count SHALL equal the population count of busy bits as of the previous edge (one-cycle latency after the bit update), range 0..NREG-1.
REQ-022 Two writes clearing two different busy registers plus one issue in one cycle SHALL all take effect together.

Reset
REQ-023 Rst_n low SHALL immediately clear all registers to 0, all busy bits to 0, Busy_count to 0, independent of Clk.
REQ-024 Writes and issues presented while Rst_n is low SHALL be discarded; the first edge after deassertion SHALL act normally.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN defined: a read whose index matches an enabled same-cycle write SHALL return that write data (port B over A) and busy 0 unless the same register is also issued that cycle.
REQ-026 Macro REGFILE_BYPASS_EN undefined: reads SHALL return the pre-edge stored value and stored busy bit.

Verification
REQ-027 Reset, write A r5=0x1234_5678, read r5 next cycle -> Read_data1=0x12345678; write r0=0xFFFF_FFFF -> Read_data1 at r0 =0.
REQ-028 Same cycle A writes r7=0x11, B writes r7=0x22 -> r7 reads 0x22.
REQ-029 Issue r3, r4 on consecutive cycles -> Read_busy for both 1, Busy_count 2; write r3 -> busy r3 0, Busy_count 1 a cycle later.
REQ-030 Issue r9 and write A r9=0xAB same cycle -> r9=0xAB, busy 1.
REQ-031 Read r6 while writing r6=0x55 same cycle -> 0x55 with REGFILE_BYPASS_EN, previous value without.
REQ-032 Fill r1..r4 busy/data, pulse Rst_n low mid-cycle -> all data, busy, Busy_count 0 before next edge.
